ecc_result_serializer: RTL

//  Downstream of the affine-translate multiplier. Captures its N-bit GF(2^m) result on the one-cycle

---
 rtl/ecc_result_serializer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ecc_result_serializer.sv
// ecc_result_serializer
// Captures an N-bit GF(2^m) result on a one-cycle valid pulse and streams it
// out as NW words of W bits, least-significant word first, over valid/ready.
// The last word is zero-padded above bit N-1. A pulse that arrives while a
// stream is in flight is dropped and latches the sticky overrun flag.
//
// Optional feature macro: FAULT_GATE_EN
//   Adds in_error / out_err. A result captured with in_error=1 is replaced
//   by all-zero words, and out_err is flagged on every word of that result.
module ecc_result_serializer #(
    parameter int N = 233,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] din,
`ifdef FAULT_GATE_EN
    input  logic         in_error,
    output logic         out_err,
`endif
    output logic         in_ready,
    output logic [W-1:0] dout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         overrun
);

    localparam int NW = (N + W - 1) / W;
    localparam int SW = NW * W;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);
    localparam logic [CW-1:0] PREV_IDX = CW'(NW - 2);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t         state;
    logic [SW-1:0]  sreg;
    logic [CW-1:0]  cnt;
    logic [SW-1:0]  load_value;
    logic           load_err;

    // Word presented to the consumer is always the low word of the shift
    // register; it drains to zero by the end of every stream.
    assign dout     = sreg[W-1:0];
    assign in_ready = (state == IDLE);

    // Value loaded on capture: zero-extended result, or all zeros when gated.
    always_comb begin
        load_value = SW'(din);
        load_err   = 1'b0;
`ifdef FAULT_GATE_EN
        if (in_error) begin
            load_value = '0;
            load_err   = 1'b1;
        end
`endif
    end

    // Capture / send FSM with registered valid, last and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
`ifdef FAULT_GATE_EN
            out_err   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= SEND;
                        sreg      <= load_value;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        out_last  <= (NW == 1);
`ifdef FAULT_GATE_EN
                        out_err   <= load_err;
`endif
                    end
                end

                SEND: begin
                    // A pulse while busy is dropped; the stream is untouched.
                    if (in_valid) begin
                        overrun <= 1'b1;
                    end
                    if (out_ready) begin
                        sreg <= sreg >> W;
                        if (cnt == LAST_IDX) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
`ifdef FAULT_GATE_EN
                            out_err   <= 1'b0;
`endif
                        end else begin
                            cnt      <= cnt + 1'b1;
                            out_last <= (cnt == PREV_IDX);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef FAULT_GATE_EN
    // Only referenced when the fault gate is built in.
    logic unused_load_err;
    assign unused_load_err = load_err;
`endif

endmodule
